// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct encodings, NOP encoding, instruction field layout.
package cpu_pkg;

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_OUT     = 2'b01;
  localparam logic [1:0] OP_SPECIAL = 2'b10;
  localparam logic [1:0] OP_NOP     = 2'b11;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_CMP = 2'b10;
  localparam logic [1:0] FN_JMP = 2'b11;

  // Opcode 11 with all other fields zero: decodes to all-zero control.
  localparam logic [7:0] NOP_INSTR = {OP_NOP, 6'b000000};

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int RA_HI  = 5;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 2;
  localparam int FN_HI  = 1;
  localparam int FN_LO  = 0;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic       vld;
    logic [7:0] instr;
    logic [7:0] pc;
  } ifid_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register. Synchronous imem (1-cycle latency); the
// memory holds its output while imem_en is low, so stalls simply freeze everything.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               PC_W     = 8,
  parameter int               INSTR_W  = 8,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               jump_valid,
  input  logic [PC_W-1:0]    jump_target,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [1:0]         id_opcode,
  output logic [1:0]         id_funct,
  output logic [1:0]         id_ra,
  output logic [1:0]         id_rb
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] pend_pc;
  logic            pend_valid;

  // A read is issued only when the pipe advances; jump and stall both suppress it.
  always_comb begin
    imem_addr = fetch_pc;
    imem_en   = !reset && !stall && !jump_valid;
  end

  // Fetch PC, in-flight read tracking and IF/ID register. Jump beats stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= NOP_W;
      id_pc      <= '0;
    end else if (jump_valid) begin
      // In-flight word and current IF/ID content are squashed to bubbles.
      fetch_pc   <= jump_target;
      pend_valid <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= NOP_W;
    end else if (!stall) begin
      pend_pc    <= fetch_pc;
      pend_valid <= 1'b1;
      fetch_pc   <= fetch_pc + PC_W'(1);
      id_valid   <= pend_valid;
      id_instr   <= pend_valid ? imem_rdata : NOP_W;
      id_pc      <= pend_pc;
    end
  end

  // Split fields are purely combinational views of the IF/ID instruction.
  always_comb begin
    id_opcode = id_instr[OPC_HI:OPC_LO];
    id_ra     = id_instr[RA_HI:RA_LO];
    id_rb     = id_instr[RB_HI:RB_LO];
    id_funct  = id_instr[FN_HI:FN_LO];
  end

endmodule
